ch4_noise_seq: RTL and testbench
================================

// Module: ch4_noise_seq
// PURPOSE
// Sequencer for APU channel 4 (noise). Consumes the decoded FF20-FF23 register fields and the frame-sequencer ticks.
// Runs the polynomial frequency timer, the 15/7-bit LFSR, the volume envelope and the length counter.
// Produces the channel-active flag and the 4-bit digital amplitude for the channel-4 DAC/mixer.
// PARAMETERS
// TIMER_W   22  width of frequency down-counter; must hold 112<<13
// DIV_ZERO  8   timer base period (clk cycles) when divisor code r=0
// DIV_STEP  16  timer base period per divisor code step (r>0: DIV_STEP*r)
// LEN_MAX   64  length counter reload value when loaded/triggered from 0
// PORTS
// clk          in   1  APU master clock; all state on rising edge
// napu_reset   in   1  async active-low reset
// ce           in   1  clock enable for frequency timer, one pulse per APU cycle
// len_tick     in   1  256 Hz frame-sequencer pulse, 1 clk wide
// env_tick     in   1  64 Hz frame-sequencer pulse, 1 clk wide
// ff20_wr      in   1  1-clk pulse: CPU write to FF20
// ff20_len     in   6  FF20 bits 5:0 (length data)
// ff21_d       in   8  FF21 latched: [7:4] init vol, [3] dir(1=up), [2:0] env period
// ff22_d       in   8  FF22 latched: [7:4] shift s, [3] width7, [2:0] divisor r
// ff23_len_en  in   1  FF23 bit 6 length enable
// ch4_restart  in   1  1-clk trigger pulse (FF23 bit 7 write)
// ch4_active   out  1  channel on (NR52 bit 3)
// ch4_amp      out  4  current amplitude: vol when active and LFSR out high, else 0
// lfsr_q       out  15 LFSR state, for debug/verification
// BEHAVIOUR
// - Reset (napu_reset=0, async): ch4_active=0, ch4_amp=0, lfsr_q=0, vol=0, timers=0, length=0.
// - DAC enable dac_en = |ff21_d[7:3]. dac_en=0 forces ch4_active=0 immediately (next clk); trigger cannot set it.
// - States: OFF, RUN. OFF->RUN on ch4_restart with dac_en; RUN->OFF on length expiry or dac_en=0.
// - Trigger (RUN or OFF):
//   - lfsr<=0; vol<=ff21_d[7:4]; env_cnt<=ff21_d[2:0].
//   - freq_cnt<=period.
//   - If length==0 then length<=LEN_MAX.
// - Period: base = (r==0)?DIV_ZERO:DIV_STEP*r; period = base<<s; s=14 or 15 => LFSR never clocks (timer frozen).
// - Freq timer: in RUN with ce=1:
//   - freq_cnt!=1 -> decrement.
//   - freq_cnt==1 -> reload period and step LFSR.
//   - The step is visible on lfsr_q the cycle after the reload edge.
// - LFSR step: x = ~(lfsr[0]^lfsr[1]); lfsr <= {x, lfsr[14:1]}; if width7 also lfsr[6] <= x.
//   - Output bit = lfsr[0]; ch4_amp = (RUN && lfsr[0]) ? vol : 0.
//   - Width change mid-run takes effect on next step.
// - Envelope: on env_tick in RUN with ff21_d[2:0]!=0:
//   - env_cnt decrements; at 0 reload ff21_d[2:0].
//   - On reload, vol +1 if dir=1 and vol<15, -1 if dir=0 and vol>0; saturates (no wrap).
//   - Period 0: envelope frozen.
// - Length: ff20_wr loads length = LEN_MAX - ff20_len, in any state.
//   - On len_tick with ff23_len_en and length!=0: decrement; reaching 0 -> ch4_active=0.
// - Simultaneity:
//   - ch4_restart beats len_tick/env_tick/ce in the same clk (ticks ignored that clk).
//   - ff20_wr beats len_tick.
//   - Trigger with len_en and length reload from 0 does not take the extra-clock quirk (plain reload to 64).
// - Reset mid-RUN: returns to OFF in all fields; no pending step survives.
// - Latency: trigger -> ch4_active=1 and new vol on ch4_amp path next clk.
// TESTING
// - Reset mid-run with vol=9 -> all outputs 0 asynchronously; trigger after release restarts with lfsr=0.
// - ff21=0xF0, ff22=0x00, trigger, ce=1 every clk -> lfsr steps every 8 clk; first step lfsr=0x4000, amp=0 until lfsr[0]=1, then 15.
// - ff22=0x08 (width7), 127 steps from trigger -> lfsr[6:0] sequence repeats with period 127; ff22=0x00 -> period 32767.
// - ff22=0xE0 (s=14) -> lfsr_q stays 0 for 10^6 clk after trigger; ff21=0x00 + trigger -> ch4_active stays 0.
// - ff20_len=62, len_en=1, trigger -> active for exactly 2 len_ticks, low after 2nd; trigger with length 0 -> 64 ticks.
// - ff21=0x0B (vol 0, up, period 3) -> vol 1 after 3 env_ticks, saturates at 15 after 45; ff21=0xF1 down -> 0 after 15, stays 0.

Source files
------------

// File: rtl/ch4_noise_seq.sv
// ch4_noise_seq: APU channel-4 noise sequencer (polynomial timer, LFSR, envelope, length counter)
module ch4_noise_seq #(
    parameter int TIMER_W  = 22,
    parameter int DIV_ZERO = 8,
    parameter int DIV_STEP = 16,
    parameter int LEN_MAX  = 64
) (
    input  logic        clk,
    input  logic        napu_reset,
    input  logic        ce,
    input  logic        len_tick,
    input  logic        env_tick,
    input  logic        ff20_wr,
    input  logic [5:0]  ff20_len,
    input  logic [7:0]  ff21_d,
    input  logic [7:0]  ff22_d,
    input  logic        ff23_len_en,
    input  logic        ch4_restart,
    output logic        ch4_active,
    output logic [3:0]  ch4_amp,
    output logic [14:0] lfsr_q
);
    localparam int LEN_W = $clog2(LEN_MAX + 1);

    typedef enum logic {OFF, RUN} state_t;

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] freq_cnt, base, period;
    logic [LEN_W-1:0]   length;
    logic [14:0]        lfsr;
    logic [3:0]         vol;
    logic [2:0]         env_cnt;
    logic               dac_en, run, frozen, timer_en, step, env_en, env_rld, len_dec, expire, lfsr_x;

    assign dac_en   = |ff21_d[7:3];
    assign run      = state == RUN;
    assign frozen   = ff22_d[7:4] > 4'd13;
    assign base     = (ff22_d[2:0] == 3'd0) ? TIMER_W'(DIV_ZERO) : TIMER_W'(DIV_STEP) * TIMER_W'(ff22_d[2:0]);
    assign period   = base << ff22_d[7:4];
    // A trigger in the same clk swallows every tick and timer enable.
    assign timer_en = run && ce && !ch4_restart && !frozen;
    assign step     = timer_en && freq_cnt <= TIMER_W'(1);
    assign env_en   = run && env_tick && !ch4_restart && ff21_d[2:0] != 3'd0;
    assign env_rld  = env_en && env_cnt <= 3'd1;
    assign len_dec  = len_tick && ff23_len_en && !ff20_wr && !ch4_restart && length != '0;
    assign expire   = len_dec && length == LEN_W'(1);
    assign lfsr_x   = ~(lfsr[0] ^ lfsr[1]);
    assign lfsr_q   = lfsr;
    assign ch4_active = run;

    always_comb begin
        state_nxt = state;
        ch4_amp   = (run && lfsr[0]) ? vol : 4'd0;
        if (!dac_en)
            state_nxt = OFF;
        else if (ch4_restart)
            state_nxt = RUN;
        else if (expire)
            state_nxt = OFF;
    end

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset)
            state <= OFF;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            freq_cnt <= '0;
            lfsr     <= '0;
            vol      <= '0;
            env_cnt  <= '0;
            length   <= '0;
        end else begin
            if (ch4_restart) begin
                lfsr     <= '0;
                vol      <= ff21_d[7:4];
                env_cnt  <= ff21_d[2:0];
                freq_cnt <= period;
            end else begin
                if (step) begin
                    freq_cnt <= period;
                    lfsr     <= {lfsr_x, lfsr[14:8], ff22_d[3] ? lfsr_x : lfsr[7], lfsr[6:1]};
                end else if (timer_en)
                    freq_cnt <= freq_cnt - 1'b1;
                if (env_rld) begin
                    env_cnt <= ff21_d[2:0];
                    if (ff21_d[3] && vol != 4'd15)
                        vol <= vol + 4'd1;
                    else if (!ff21_d[3] && vol != 4'd0)
                        vol <= vol - 4'd1;
                end else if (env_en)
                    env_cnt <= env_cnt - 3'd1;
            end
            if (ff20_wr)
                length <= LEN_W'(LEN_MAX) - LEN_W'(ff20_len);
            else if (ch4_restart && length == '0)
                length <= LEN_W'(LEN_MAX);
            else if (len_dec)
                length <= length - 1'b1;
        end
    end
endmodule

// File: tb/tb_ch4_noise_seq.sv
// tb_ch4_noise_seq: randomized and directed checks of ch4_noise_seq against a behavioural channel model
module tb_ch4_noise_seq;
    logic        clk = 0, napu_reset = 0, ce = 0, len_tick = 0, env_tick = 0;
    logic        ff20_wr = 0, ff23_len_en = 0, ch4_restart = 0;
    logic [5:0]  ff20_len = 0;
    logic [7:0]  ff21_d = 0, ff22_d = 0;
    logic        ch4_active;
    logic [3:0]  ch4_amp;
    logic [14:0] lfsr_q;
    int checks = 0, errors = 0;
    int m_on, m_lfsr, m_vol, m_env, m_ce, m_len;

    ch4_noise_seq dut (
        .clk(clk), .napu_reset(napu_reset), .ce(ce), .len_tick(len_tick), .env_tick(env_tick),
        .ff20_wr(ff20_wr), .ff20_len(ff20_len), .ff21_d(ff21_d), .ff22_d(ff22_d),
        .ff23_len_en(ff23_len_en), .ch4_restart(ch4_restart),
        .ch4_active(ch4_active), .ch4_amp(ch4_amp), .lfsr_q(lfsr_q)
    );

    always #5 clk = ~clk;

    function automatic int m_amp();
        return (m_on != 0 && (m_lfsr & 1) != 0) ? m_vol : 0;
    endfunction

    task automatic model_clear();
        m_on = 0; m_lfsr = 0; m_vol = 0; m_env = 0; m_ce = 0; m_len = 0;
    endtask

    // Advance the model by one clk from the current inputs, then move past the edge.
    task automatic cyc();
        int on = m_on;
        int s = int'(ff22_d[7:4]);
        int r = int'(ff22_d[2:0]);
        int per = (r == 0 ? 8 : 16 * r) << s;
        int p = int'(ff21_d[2:0]);
        int x;
        if (ch4_restart) begin
            m_lfsr = 0; m_vol = int'(ff21_d[7:4]); m_env = 0; m_ce = 0;
            if (ff20_wr) m_len = 64 - int'(ff20_len);
            else if (m_len == 0) m_len = 64;
            m_on = (ff21_d[7:3] != 0) ? 1 : 0;
        end else begin
            if (ff20_wr) m_len = 64 - int'(ff20_len);
            else if (len_tick && ff23_len_en && m_len != 0) begin
                m_len--;
                if (m_len == 0) m_on = 0;
            end
            if (on != 0 && ce && s < 14) begin
                m_ce++;
                if (m_ce >= per) begin
                    m_ce = 0;
                    x = ((m_lfsr ^ (m_lfsr >> 1)) & 1) ^ 1;
                    m_lfsr = (m_lfsr >> 1) | (x << 14);
                    if (ff22_d[3]) m_lfsr = (m_lfsr & ~64) | (x << 6);
                end
            end
            if (on != 0 && env_tick && p != 0) begin
                m_env++;
                if (m_env >= p) begin
                    m_env = 0;
                    if (ff21_d[3] && m_vol < 15) m_vol++;
                    else if (!ff21_d[3] && m_vol > 0) m_vol--;
                end
            end
            if (ff21_d[7:3] == 0) m_on = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic trigger();
        ch4_restart = 1;
        cyc();
        ch4_restart = 0;
    endtask

    task automatic step_until_lit(input string name);
        int n = 0;
        ce = 1;
        while ((m_lfsr & 1) == 0 && n < 400) begin
            cyc();
            n++;
        end
        ce = 0;
        checks++;
        if ((m_lfsr & 1) == 0 || lfsr_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s lfsr_lit timeout lfsr=%h model=%h", name, lfsr_q, m_lfsr);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({ch4_active, ch4_amp, lfsr_q} !== 20'd0) begin
            errors++;
            $display("FAIL reset_held got %b/%h/%h want 0/0/0", ch4_active, ch4_amp, lfsr_q);
        end
        napu_reset = 1;
        repeat (2) cyc();
        checks++;
        if ({ch4_active, ch4_amp, lfsr_q} !== 20'd0) begin
            errors++;
            $display("FAIL reset_released got %b/%h/%h want 0/0/0", ch4_active, ch4_amp, lfsr_q);
        end
    endtask

    task automatic test_basic_lfsr();
        ff21_d = 8'hF0; ff22_d = 8'h00; ff23_len_en = 0; ce = 1;
        trigger();
        repeat (7) cyc();
        checks++;
        if (lfsr_q !== 15'h0000 || ch4_active !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_step got lfsr=%h act=%b want 0000/1", lfsr_q, ch4_active);
        end
        cyc();
        checks++;
        if (lfsr_q !== 15'h4000 || ch4_amp !== 4'd0) begin
            errors++;
            $display("FAIL basic_first_step got lfsr=%h amp=%h want 4000/0", lfsr_q, ch4_amp);
        end
        for (int i = 0; i < 200; i++) begin
            cyc();
            checks++;
            if (lfsr_q !== 15'(m_lfsr) || ch4_amp !== (((m_lfsr & 1) != 0) ? 4'd15 : 4'd0)) begin
                errors++;
                $display("FAIL basic_run cyc %0d got lfsr=%h amp=%h want %h/%0d", i, lfsr_q, ch4_amp, m_lfsr, ((m_lfsr & 1) != 0) ? 15 : 0);
            end
        end
        ce = 0;
    endtask

    task automatic test_width7();
        logic [6:0] seq [0:254];
        ff21_d = 8'hF0; ff22_d = 8'h08; ce = 1;
        trigger();
        for (int k = 0; k <= 254; k++) begin
            if (k > 0) repeat (8) cyc();
            seq[k] = lfsr_q[6:0];
            checks++;
            if (lfsr_q !== 15'(m_lfsr)) begin
                errors++;
                $display("FAIL width7_step %0d got %h want %h", k, lfsr_q, m_lfsr);
            end
        end
        for (int k = 0; k < 127; k++) begin
            checks++;
            if (seq[k + 127] !== seq[k]) begin
                errors++;
                $display("FAIL width7_period idx %0d got %h want %h", k, seq[k + 127], seq[k]);
            end
        end
        ce = 0;
    endtask

    task automatic test_frozen();
        logic moved = 0;
        ff21_d = 8'hF0; ff22_d = 8'hE0; ce = 1;
        trigger();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) ff22_d = 8'hF7;
            cyc();
            if (lfsr_q !== 15'd0) moved = 1;
        end
        checks++;
        if (moved !== 1'b0 || ch4_active !== 1'b1) begin
            errors++;
            $display("FAIL frozen got moved=%b act=%b want 0/1", moved, ch4_active);
        end
        ff21_d = 8'h00;
        trigger();
        checks++;
        if (ch4_active !== 1'b0) begin
            errors++;
            $display("FAIL dac_off_trigger got %b want 0", ch4_active);
        end
        repeat (10) cyc();
        checks++;
        if (ch4_active !== 1'b0 || ch4_amp !== 4'd0) begin
            errors++;
            $display("FAIL dac_off_hold got %b/%h want 0/0", ch4_active, ch4_amp);
        end
        ce = 0;
    endtask

    task automatic test_length();
        ff21_d = 8'hF0; ff22_d = 8'hE0; ff23_len_en = 1;
        ff20_len = 6'd62; ff20_wr = 1;
        cyc();
        ff20_wr = 0;
        trigger();
        for (int t = 1; t <= 2; t++) begin
            len_tick = 1; cyc(); len_tick = 0; cyc();
            checks++;
            if (ch4_active !== (t < 2)) begin
                errors++;
                $display("FAIL len62_tick %0d got %b want %b", t, ch4_active, t < 2);
            end
        end
        trigger();
        for (int t = 1; t <= 64; t++) begin
            len_tick = 1; cyc(); len_tick = 0; cyc();
            if (t >= 63) begin
                checks++;
                if (ch4_active !== (t < 64)) begin
                    errors++;
                    $display("FAIL len64_tick %0d got %b want %b", t, ch4_active, t < 64);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        ff21_d = 8'hF0; ff22_d = 8'hE0; ff23_len_en = 1;
        ff20_len = 6'd63; ff20_wr = 1; cyc(); ff20_wr = 0;
        trigger();
        ch4_restart = 1; len_tick = 1; cyc(); ch4_restart = 0; len_tick = 0;
        checks++;
        if (ch4_active !== 1'b1) begin
            errors++;
            $display("FAIL restart_beats_len got %b want 1", ch4_active);
        end
        ff20_wr = 1; len_tick = 1; cyc(); ff20_wr = 0; len_tick = 0;
        checks++;
        if (ch4_active !== 1'b1) begin
            errors++;
            $display("FAIL wr_beats_len got %b want 1", ch4_active);
        end
        len_tick = 1; cyc(); len_tick = 0;
        checks++;
        if (ch4_active !== 1'b0) begin
            errors++;
            $display("FAIL len1_expire got %b want 0", ch4_active);
        end
        ff23_len_en = 0;
    endtask

    task automatic test_envelope();
        ff21_d = 8'h0B; ff22_d = 8'h00;
        trigger();
        step_until_lit("env_up");
        for (int n = 1; n <= 48; n++) begin
            env_tick = 1; cyc(); env_tick = 0; cyc();
            if (n == 2 || n == 3 || n == 44 || n == 45 || n == 48) begin
                checks++;
                if (ch4_amp !== 4'((n / 3 > 15) ? 15 : n / 3)) begin
                    errors++;
                    $display("FAIL env_up n=%0d got %0d want %0d", n, ch4_amp, (n / 3 > 15) ? 15 : n / 3);
                end
            end
        end
        ff21_d = 8'hF1;
        trigger();
        step_until_lit("env_down");
        for (int n = 1; n <= 20; n++) begin
            env_tick = 1; cyc(); env_tick = 0; cyc();
            if (n == 1 || n == 14 || n == 15 || n == 20) begin
                checks++;
                if (ch4_amp !== 4'((15 - n < 0) ? 0 : 15 - n) || ch4_active !== 1'b1) begin
                    errors++;
                    $display("FAIL env_down n=%0d got %0d/%b want %0d/1", n, ch4_amp, ch4_active, (15 - n < 0) ? 0 : 15 - n);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        ff21_d = 8'h90; ff22_d = 8'h00;
        trigger();
        step_until_lit("reset_midrun");
        checks++;
        if (ch4_amp !== 4'd9) begin
            errors++;
            $display("FAIL midrun_amp got %0d want 9", ch4_amp);
        end
        #2 napu_reset = 0;
        #1;
        checks++;
        if ({ch4_active, ch4_amp, lfsr_q} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset got %b/%h/%h want 0/0/0", ch4_active, ch4_amp, lfsr_q);
        end
        model_clear();
        repeat (2) cyc();
        napu_reset = 1;
        cyc();
        trigger();
        checks++;
        if (ch4_active !== 1'b1 || lfsr_q !== 15'd0 || ch4_amp !== 4'd0) begin
            errors++;
            $display("FAIL restart_after_reset got %b/%h/%h want 1/0/0", ch4_active, ch4_amp, lfsr_q);
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            ff21_d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            ff22_d = {4'($urandom_range(0, 2)), 1'($urandom), 3'($urandom)};
            ff23_len_en = 1'($urandom);
            ff20_len = 6'($urandom_range(40, 63));
            ff20_wr = 1;
            trigger();
            ff20_wr = 0;
            for (int i = 0; i < 600; i++) begin
                ce = ($urandom_range(0, 3) != 0);
                len_tick = ($urandom_range(0, 29) == 0);
                env_tick = ($urandom_range(0, 9) == 0);
                ff20_wr = ($urandom_range(0, 199) == 0);
                ff20_len = 6'($urandom);
                ch4_restart = ($urandom_range(0, 249) == 0);
                if ($urandom_range(0, 99) == 0) ff22_d[3] = ~ff22_d[3];
                cyc();
                checks++;
                if ({ch4_active, ch4_amp, lfsr_q} !== {1'(m_on), 4'(m_amp()), 15'(m_lfsr)}) begin
                    errors++;
                    $display("FAIL random run %0d cyc %0d got %b/%h/%h want %0d/%0d/%h", run, i, ch4_active, ch4_amp, lfsr_q, m_on, m_amp(), m_lfsr);
                end
            end
        end
        ce = 0; len_tick = 0; env_tick = 0; ff20_wr = 0; ch4_restart = 0;
    endtask

    initial begin
        model_clear();
        repeat (3) cyc();
        test_reset();
        test_basic_lfsr();
        test_width7();
        test_frozen();
        test_length();
        test_simultaneous();
        test_envelope();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
